// File: rtl/ws2812_write_arbiter_if.sv
// Requester channels r0/r1 and the ws2812 pixel-write port of ws2812_write_arbiter.
// master = requester/observer side, slave = the arbiter itself.
interface ws2812_write_arbiter_if #(
    parameter int LED_W = 8
);
    logic             r0_valid;
    logic             r0_ready;
    logic [LED_W-1:0] r0_led_num;
    logic [23:0]      r0_rgb;
    logic             r1_valid;
    logic             r1_ready;
    logic [LED_W-1:0] r1_led_num;
    logic [23:0]      r1_rgb;
    logic             out_write;
    logic [LED_W-1:0] out_led_num;
    logic [23:0]      out_rgb;
    logic             err_range;
    logic             busy;

    modport master (
        output r0_valid, r0_led_num, r0_rgb, r1_valid, r1_led_num, r1_rgb,
        input  r0_ready, r1_ready, out_write, out_led_num, out_rgb, err_range, busy
    );

    modport slave (
        input  r0_valid, r0_led_num, r0_rgb, r1_valid, r1_led_num, r1_rgb,
        output r0_ready, r1_ready, out_write, out_led_num, out_rgb, err_range, busy
    );
endinterface

// File: rtl/ws2812_write_arbiter.sv
// Round-robin arbiter sharing the ws2812 pixel-write port between two requesters.
// Optional whole-chain fill engine enabled by defining WS2812_FILL_EN.
module ws2812_write_arbiter #(
    parameter int NUM_LEDS  = 64,
    parameter int LED_W     = 8,
    parameter int WRITE_GAP = 2
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef WS2812_FILL_EN
    input  logic                 fill_start,
    input  logic [23:0]          fill_rgb,
    output logic                 fill_done,
`endif
    ws2812_write_arbiter_if.slave bus
);

`ifdef WS2812_FILL_EN
    typedef enum logic [1:0] {IDLE, ISSUE, GAP, FILL} state_t;
    localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);
`else
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
`endif

    // Extra bit so NUM_LEDS == 2**LED_W still compares correctly.
    localparam logic [LED_W:0] LED_LIMIT = (LED_W + 1)'(NUM_LEDS);

    state_t           state;
    logic [7:0]       gap_cnt;
    logic             rr_r1;
    logic             idle;
    logic             fill_req;
    logic             grant_r1;
    logic             accept;
    logic             sel_bad;
    logic             write_done;
    logic [LED_W-1:0] sel_led;
    logic [23:0]      sel_rgb;

`ifdef WS2812_FILL_EN
    logic             fill_active;
    logic [LED_W-1:0] fill_idx;
    logic [23:0]      fill_color;

    assign fill_req = (state == IDLE) && fill_start;
`else
    assign fill_req = 1'b0;
`endif

    assign idle         = (state == IDLE);
    // rr_r1 set means r1 wins a collision because r0 was granted last.
    assign grant_r1     = bus.r1_valid && (!bus.r0_valid || rr_r1);
    assign bus.r0_ready = idle && !fill_req && bus.r0_valid && !grant_r1;
    assign bus.r1_ready = idle && !fill_req && grant_r1;
    assign accept       = bus.r0_ready || bus.r1_ready;
    assign sel_led      = grant_r1 ? bus.r1_led_num : bus.r0_led_num;
    assign sel_rgb      = grant_r1 ? bus.r1_rgb : bus.r0_rgb;
    assign sel_bad      = {1'b0, sel_led} >= LED_LIMIT;
    assign write_done   = ((state == ISSUE) && (WRITE_GAP == 0)) ||
                          ((state == GAP) && (gap_cnt == 8'd0));
    assign bus.busy     = !idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            gap_cnt         <= 8'd0;
            rr_r1           <= 1'b0;
            bus.out_write   <= 1'b0;
            bus.out_led_num <= '0;
            bus.out_rgb     <= 24'd0;
            bus.err_range   <= 1'b0;
`ifdef WS2812_FILL_EN
            fill_active     <= 1'b0;
            fill_idx        <= '0;
            fill_color      <= 24'd0;
            fill_done       <= 1'b0;
`endif
        end else begin
            bus.out_write <= 1'b0;
            bus.err_range <= 1'b0;
`ifdef WS2812_FILL_EN
            fill_done     <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef WS2812_FILL_EN
                    if (fill_req) begin
                        state           <= ISSUE;
                        fill_active     <= 1'b1;
                        fill_idx        <= '0;
                        fill_color      <= fill_rgb;
                        bus.out_write   <= 1'b1;
                        bus.out_led_num <= '0;
                        bus.out_rgb     <= fill_rgb;
                    end
`endif
                    // Out-of-range requests are consumed but never reach the chain.
                    if (accept) begin
                        rr_r1 <= !grant_r1;
                        if (sel_bad) begin
                            bus.err_range <= 1'b1;
                        end else begin
                            state           <= ISSUE;
                            bus.out_write   <= 1'b1;
                            bus.out_led_num <= sel_led;
                            bus.out_rgb     <= sel_rgb;
                        end
                    end
                end
                ISSUE: begin
                    if (WRITE_GAP != 0) begin
                        state   <= GAP;
                        gap_cnt <= 8'(WRITE_GAP - 1);
                    end
                end
                GAP: begin
                    if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
                end
`ifdef WS2812_FILL_EN
                FILL: begin
                    state           <= ISSUE;
                    bus.out_write   <= 1'b1;
                    bus.out_led_num <= fill_idx;
                    bus.out_rgb     <= fill_color;
                end
`endif
                default: state <= IDLE;
            endcase

            if (write_done) begin
`ifdef WS2812_FILL_EN
                if (!fill_active) begin
                    state <= IDLE;
                end else if (fill_idx == LAST_LED) begin
                    state       <= IDLE;
                    fill_active <= 1'b0;
                    fill_done   <= 1'b1;
                end else begin
                    state    <= FILL;
                    fill_idx <= fill_idx + 1'b1;
                end
`else
                state <= IDLE;
`endif
            end
        end
    end

endmodule
